pcpi_share_arbiter: RTL and testbench
=====================================

// Module: pcpi_share_arbiter
// PURPOSE
//  Shares one fused_matrix_mult_pcpi coprocessor between two instruction requesters.
//  Example requesters: the nibble-serial host loader and an on-chip sequencer.
//  Round-robin grant. Drives the PCPI valid/insn handshake and returns rd/wr to the winner.
//  A timeout counter catches an unresponsive coprocessor and ends the job with an error.
// PARAMETERS
//  TIMEOUT  64  cycles pcpi_valid may stay high with pcpi_wait=0 and no pcpi_ready before abort (>=2)
// PORTS
//  clk          in   1   single clock, all state on posedge
//  rst          in   1   asynchronous, active-high reset
//  req0_valid   in   1   requester 0 has an instruction
//  req0_insn    in   32  requester 0 instruction
//  req0_ready   out  1   requester 0 instruction accepted this cycle (valid&&ready = transfer)
//  rsp0_valid   out  1   one-cycle pulse: result for requester 0
//  req1_valid   in   1   requester 1 has an instruction
//  req1_insn    in   32  requester 1 instruction
//  req1_ready   out  1   requester 1 instruction accepted this cycle
//  rsp1_valid   out  1   one-cycle pulse: result for requester 1
//  rsp_rd       out  32  result data (shared; qualified by rspN_valid, held until next response)
//  rsp_wr       out  1   coprocessor requested register write-back
//  rsp_err      out  1   job aborted by timeout (rsp_rd=0, rsp_wr=0)
//  pcpi_valid   out  1   to coprocessor
//  pcpi_insn    out  32  to coprocessor, stable while pcpi_valid=1
//  pcpi_ready   in   1   from coprocessor
//  pcpi_wr      in   1   from coprocessor
//  pcpi_rd      in   32  from coprocessor
//  pcpi_wait    in   1   coprocessor has claimed the instruction and is busy
//  busy         out  1   state != IDLE
//  grant_id     out  1   requester owning the current or last job
// BEHAVIOUR
//  Reset values:
//   - All outputs 0. State IDLE. Counter 0. pcpi_insn 0.
//   - last_grant=1, so requester 0 wins the first tie.
//  FSM: IDLE -> ISSUE -> RESP -> IDLE.
//  IDLE:
//   - reqN_ready is combinational, asserted only for the selected requester.
//   - Only one requester is valid: select it.
//   - Both valid: select !last_grant.
//   - On transfer: latch insn into pcpi_insn, set grant_id=N and last_grant=N, clear the counter, go to ISSUE.
//  ISSUE:
//   - pcpi_valid=1, held continuously (no pulse). New requests are not accepted (reqN_ready=0).
//   - pcpi_ready=1: capture pcpi_rd/pcpi_wr into rsp_rd/rsp_wr, set rsp_err=0, drop pcpi_valid, go to RESP.
//   - pcpi_wait=1: counter cleared every cycle; no timeout while the coprocessor is busy.
//   - Else counter+1. On reaching TIMEOUT-1 with pcpi_ready=0: set rsp_err=1, rsp_rd=0, rsp_wr=0, drop pcpi_valid, go to RESP.
//   - pcpi_ready and timeout in the same cycle: ready wins, no error.
//  RESP:
//   - rsp{grant_id}_valid=1 for exactly one cycle, then IDLE.
//  Latency:
//   - Transfer at cycle T gives pcpi_valid high from T+1.
//   - pcpi_ready at cycle R gives pcpi_valid low at R+1 and rspN_valid at R+1.
//   - Earliest next accept is R+2.
//  Edge cases:
//   - pcpi_ready while pcpi_valid=0 is ignored.
//   - reqN_valid may drop while not granted; no state is kept for it.
//   - rst asserted mid-job: immediate return to reset values. The job is dropped, no rsp pulse, pcpi_valid falls asynchronously.
//   - Fairness: a requester waits at most one job while the other is also continuously requesting.
// TESTING
//  1. Single job: req0 insn=0x0200_000B; coprocessor returns ready after 3 cycles, rd=0x1234_5678, wr=1.
//     Expect rsp0_valid 1 cycle, rsp_rd=0x12345678, rsp_wr=1, rsp_err=0, grant_id=0.
//  2. Tie after reset: req0 and req1 both valid. Expect order req0, req1, req0.
//     Check grant_id per rsp and that rsp1_valid never coincides with rsp0_valid.
//  3. Timeout: pcpi_ready=0, pcpi_wait=0. Expect pcpi_valid high exactly 64 cycles,
//     then rsp_err=1 with rsp_rd=0 and rsp_wr=0.
//  4. Long busy: pcpi_wait=1 for 200 cycles, then ready with rd=0xCAFE0001. Expect no error and the correct rd.
//  5. Ready on the timeout cycle: pcpi_ready exactly on cycle 64. Expect rsp_err=0 and data captured.
//  6. Reset mid-ISSUE: rst pulsed. Expect pcpi_valid=0 and busy=0 immediately, no rsp pulse.
//     Next tie is granted to req0.

Source files
------------

// File: rtl/pcpi_share_arbiter.sv
// Round-robin arbiter that shares one PCPI coprocessor between two instruction requesters.
// A watchdog counter ends a job with rsp_err when the coprocessor neither claims nor answers it.
module pcpi_share_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_insn,
  output logic        req0_ready,
  output logic        rsp0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req1_insn,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp_rd,
  output logic        rsp_wr,
  output logic        rsp_err,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  output logic        busy,
  output logic        grant_id
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last_grant;
  logic          r_grant_id;
  logic          r_pcpi_valid;
  logic [31:0]   r_pcpi_insn;
  logic          r_rsp0_valid;
  logic          r_rsp1_valid;
  logic [31:0]   r_rsp_rd;
  logic          r_rsp_wr;
  logic          r_rsp_err;
  logic [CW-1:0] r_cnt;

  logic w_idle;
  logic w_any;
  logic w_sel;

  // On a tie the requester that did not win last time is selected.
  assign w_idle = (r_state == S_IDLE);
  assign w_any  = req0_valid | req1_valid;
  assign w_sel  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

  assign req0_ready = w_idle & w_any & ~w_sel;
  assign req1_ready = w_idle & w_any &  w_sel;

  assign pcpi_valid = r_pcpi_valid;
  assign pcpi_insn  = r_pcpi_insn;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_rd     = r_rsp_rd;
  assign rsp_wr     = r_rsp_wr;
  assign rsp_err    = r_rsp_err;
  assign busy       = ~w_idle;
  assign grant_id   = r_grant_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_pcpi_valid <= 1'b0;
      r_pcpi_insn  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_rd     <= '0;
      r_rsp_wr     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_pcpi_insn  <= w_sel ? req1_insn : req0_insn;
            r_grant_id   <= w_sel;
            r_last_grant <= w_sel;
            r_cnt        <= '0;
            r_pcpi_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A response arriving on the last watchdog cycle still counts as a success.
          if (pcpi_ready) begin
            r_rsp_rd     <= pcpi_rd;
            r_rsp_wr     <= pcpi_wr;
            r_rsp_err    <= 1'b0;
            r_pcpi_valid <= 1'b0;
            r_rsp0_valid <= ~r_grant_id;
            r_rsp1_valid <=  r_grant_id;
            r_state      <= S_RESP;
          end else if (pcpi_wait) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_rd     <= '0;
            r_rsp_wr     <= 1'b0;
            r_rsp_err    <= 1'b1;
            r_pcpi_valid <= 1'b0;
            r_rsp0_valid <= ~r_grant_id;
            r_rsp1_valid <=  r_grant_id;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_share_arbiter.sv
// Bench for pcpi_share_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a job-timeline model.
module tb_pcpi_share_arbiter;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_insn, req1_insn;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_rd;
  logic        rsp_wr, rsp_err;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready, pcpi_wr, pcpi_wait;
  logic [31:0] pcpi_rd;
  logic        busy, grant_id;

  int n_cmp  = 0;
  int n_fail = 0;

  pcpi_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_insn(req0_insn), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_insn(req1_insn), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_rd(rsp_rd), .rsp_wr(rsp_wr), .rsp_err(rsp_err),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_ready(pcpi_ready),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_insn = '0; req1_insn = '0;
    pcpi_ready = 1'b0; pcpi_wait = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Called in the accept cycle; returns in the first idle cycle after the response.
  task automatic run_job(input logic [31:0] insn, input bit gid, input int w, input int d,
                         input logic [31:0] rd, input bit wr);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < w + d; k++) begin
      pcpi_wait = (k < w);
      tick();
    end
    pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_rd = rd; pcpi_wr = wr;
    #1;
    chk("job_valid_at_ready", pcpi_valid, 1);
    chk("job_insn", pcpi_insn, insn);
    chk("job_grant_id", grant_id, gid);
    chk("job_busy", busy, 1);
    chk("job_no_ready", {req0_ready, req1_ready}, 0);
    tick();
    pcpi_ready = 1'b0; pcpi_rd = $urandom; pcpi_wr = 1'b0;
    #1;
    chk("resp_valid_low", pcpi_valid, 0);
    chk("resp_rsp0", rsp0_valid, !gid);
    chk("resp_rsp1", rsp1_valid, gid);
    chk("resp_rd", rsp_rd, rd);
    chk("resp_wr", rsp_wr, wr);
    chk("resp_err", rsp_err, 0);
    tick();
    #1;
    chk("after_rsp_pulse", {rsp0_valid, rsp1_valid}, 0);
    chk("after_busy", busy, 0);
  endtask

  typedef struct {
    bit          v0;
    bit          v1;
    logic [31:0] i0;
    logic [31:0] i1;
    bit          xfer;
    bit          gid;
    int          w;
    int          d;
    logic [31:0] rd;
    bit          wr;
  } vec_t;

  vec_t tbl[10];

  // Random-phase model: each accepted job is reduced to a timeline computed at accept time.
  bit          m_job, m_gid, m_last, m_err, m_wr;
  int          m_T, m_L, sa, sw, sd;
  logic [31:0] m_insn, m_rd;
  bit          p0, p1;
  logic [31:0] q0, q1;

  initial begin
    int cnt;
    tbl[0] = '{1'b1, 1'b1, 32'h0200_000B, 32'h0BAD_0001, 1'b1, 1'b0, 0, 3, 32'h1234_5678, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_100B, 32'h0000_200B, 1'b1, 1'b1, 0, 0, 32'hA5A5_A5A5, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_300B, 32'h0000_400B, 1'b1, 1'b0, 0, 1, 32'h0000_0001, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_500B, 32'h0000_600B, 1'b1, 1'b1, 0, 2, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_700B, 32'h0000_800B, 1'b1, 1'b1, 5, 0, 32'h8000_0000, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_900B, 32'h0000_A00B, 1'b1, 1'b0, 0, 0, 32'h7FFF_FFFF, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_B00B, 32'h0000_C00B, 1'b1, 1'b0, 0, 4, 32'h0F0F_0F0F, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h0000_D00B, 32'h0000_E00B, 1'b0, 1'b0, 0, 0, 32'h0000_0000, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 32'h0000_F00B, 32'h0001_000B, 1'b1, 1'b1, 2, 2, 32'h1357_9BDF, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 32'h0001_100B, 32'h0001_200B, 1'b1, 1'b0, 0, 0, 32'h2468_ACE0, 1'b0};

    do_reset();
    #1;
    chk("reset_pcpi_valid", pcpi_valid, 0);
    chk("reset_pcpi_insn", pcpi_insn, 0);
    chk("reset_rsp", {rsp0_valid, rsp1_valid, rsp_wr, rsp_err}, 0);
    chk("reset_rsp_rd", rsp_rd, 0);
    chk("reset_busy_grant", {busy, grant_id}, 0);

    for (int i = 0; i < 10; i++) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_insn  = tbl[i].i0; req1_insn  = tbl[i].i1;
      #1;
      chk("tbl_ready0", req0_ready, tbl[i].xfer && !tbl[i].gid);
      chk("tbl_ready1", req1_ready, tbl[i].xfer && tbl[i].gid);
      if (tbl[i].xfer)
        run_job(tbl[i].gid ? tbl[i].i1 : tbl[i].i0, tbl[i].gid, tbl[i].w, tbl[i].d,
                tbl[i].rd, tbl[i].wr);
      else
        tick();
    end

    // Unresponsive coprocessor: watchdog abort after TO cycles of pcpi_valid.
    req0_valid = 1'b1; req0_insn = 32'h0300_000B; req1_valid = 1'b0;
    #1;
    chk("to_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    cnt = 0;
    while (pcpi_valid === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    #1;
    chk("to_valid_cycles", cnt, TO);
    chk("to_rsp0", rsp0_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_rd", rsp_rd, 0);
    chk("to_wr", rsp_wr, 0);
    tick();
    #1;
    chk("to_pulse_end", rsp0_valid, 0);

    // Long busy period must never time out.
    req1_valid = 1'b1; req1_insn = 32'h0400_000B;
    #1;
    chk("busy_ready1", req1_ready, 1);
    run_job(32'h0400_000B, 1'b1, 200, 0, 32'hCAFE_0001, 1'b1);

    // Response on the very last watchdog cycle wins over the abort.
    req0_valid = 1'b1; req0_insn = 32'h0500_000B;
    #1;
    chk("edge_ready0", req0_ready, 1);
    run_job(32'h0500_000B, 1'b0, 0, TO - 1, 32'h5EED_0064, 1'b1);

    // Reset in the middle of a job drops it and restores the initial tie-break.
    req0_valid = 1'b1; req0_insn = 32'h0600_000B;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_pcpi_valid", pcpi_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pcpi_insn", pcpi_insn, 0);
    chk("rst_rsp_rd", rsp_rd, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_no_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
      tick();
    end
    req0_valid = 1'b1; req0_insn = 32'h0700_000B;
    req1_valid = 1'b1; req1_insn = 32'h0800_000B;
    #1;
    chk("rst_tie_ready0", req0_ready, 1);
    chk("rst_tie_ready1", req1_ready, 0);
    run_job(32'h0700_000B, 1'b0, 0, 1, 32'h0000_0ACE, 1'b0);

    // Random traffic against the timeline model.
    do_reset();
    m_job = 1'b0; m_last = 1'b1; m_T = 0; m_L = 0; p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      bit in_win, free, win, e_r0, e_r1, rsp_cyc;
      int k;
      if (p0 && $urandom_range(15) == 0) p0 = 1'b0;
      else if (!p0 && $urandom_range(2) == 0) begin p0 = 1'b1; q0 = $urandom; end
      if (p1 && $urandom_range(15) == 0) p1 = 1'b0;
      else if (!p1 && $urandom_range(2) == 0) begin p1 = 1'b1; q1 = $urandom; end
      req0_valid = p0; req0_insn = p0 ? q0 : $urandom;
      req1_valid = p1; req1_insn = p1 ? q1 : $urandom;

      k       = c - (m_T + 1);
      in_win  = m_job && (c >= m_T + 1) && (c <= m_T + m_L);
      rsp_cyc = m_job && (c == m_T + m_L + 1);
      free    = !m_job || (c >= m_T + m_L + 2);
      pcpi_ready = 1'b0; pcpi_wait = 1'b0; pcpi_rd = $urandom; pcpi_wr = 1'($urandom_range(1));
      if (in_win) begin
        if (k >= sa && k < sa + sw) pcpi_wait = 1'b1;
        else if (k == sa + sw + sd) begin pcpi_ready = 1'b1; pcpi_rd = m_rd; pcpi_wr = m_wr; end
      end else begin
        pcpi_ready = ($urandom_range(3) == 0);
        pcpi_wait  = ($urandom_range(3) == 0);
      end

      win  = (p0 && p1) ? !m_last : p1;
      e_r0 = free && (p0 || p1) && !win;
      e_r1 = free && (p0 || p1) && win;
      #1;
      chk("rnd_ready0", req0_ready, e_r0);
      chk("rnd_ready1", req1_ready, e_r1);
      chk("rnd_pcpi_valid", pcpi_valid, in_win);
      if (in_win) chk("rnd_pcpi_insn", pcpi_insn, m_insn);
      chk("rnd_busy", busy, m_job && (c >= m_T + 1) && (c <= m_T + m_L + 1));
      chk("rnd_rsp0", rsp0_valid, rsp_cyc && !m_gid);
      chk("rnd_rsp1", rsp1_valid, rsp_cyc && m_gid);
      if (rsp_cyc) begin
        chk("rnd_rsp_err", rsp_err, m_err);
        chk("rnd_rsp_rd", rsp_rd, m_err ? 32'h0 : m_rd);
        chk("rnd_rsp_wr", rsp_wr, m_err ? 1'b0 : m_wr);
      end
      if (m_job && c >= m_T + 1) chk("rnd_grant_id", grant_id, m_gid);

      if (free && (p0 || p1)) begin
        m_job = 1'b1; m_T = c; m_gid = win; m_last = win;
        m_insn = win ? q1 : q0;
        if (win) p1 = 1'b0; else p0 = 1'b0;
        sa = ($urandom_range(9) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 4);
        sw = ($urandom_range(1) == 0) ? $urandom_range(1, 12) : 0;
        sd = ($urandom_range(5) == 0) ? $urandom_range(TO - 4, TO + 3) : $urandom_range(0, 5);
        if (sw == 0) begin sd = sd + sa; sa = 0; end
        m_err = (sa >= TO) || (sd >= TO);
        m_L   = (sa >= TO) ? TO : (sd >= TO) ? sa + sw + TO : sa + sw + sd + 1;
        m_rd  = $urandom;
        m_wr  = 1'($urandom_range(1));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d, failed %0d", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
